// File: rtl/pulse_hs_pkg.sv
// Shared state encodings and default parameters for the four-phase pulse
// request sender and its acknowledge synchronizer.
package pulse_hs_pkg;

  localparam int unsigned SYNC_STAGES_DEF    = 2;
  localparam int unsigned PEND_WIDTH_DEF     = 4;
  localparam int unsigned TIMEOUT_CYCLES_DEF = 1024;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE        = 2'd0;
  localparam state_t ST_REQ_HI      = 2'd1;
  localparam state_t ST_ACK_WAIT_LO = 2'd2;

endpackage

// File: rtl/sync_ff_chain.sv
// Multi-flop synchronizer for a single asynchronous level; q is the last stage.
module sync_ff_chain
  import pulse_hs_pkg::*;
#(
  parameter int unsigned STAGES = SYNC_STAGES_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk) begin
    if (reset) begin
      chain <= '0;
    end else begin
      chain <= {chain[STAGES-2:0], d};
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/pulse_req_sender.sv
// Four-phase request sender: turns rising edges of signal_in into req/ack
// handshakes, queuing surplus events in a saturating pending counter.
module pulse_req_sender
  import pulse_hs_pkg::*;
#(
  parameter int unsigned SYNC_STAGES    = SYNC_STAGES_DEF,
  parameter int unsigned PEND_WIDTH     = PEND_WIDTH_DEF,
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  signal_in,
  input  logic                  ack_in,
  output logic                  req_out,
  output logic                  busy,
  output logic                  done,
  output logic [PEND_WIDTH-1:0] pending,
  output logic                  overflow,
  output logic                  timeout_err
);

  localparam int unsigned           TO_W     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0]       TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [PEND_WIDTH-1:0] PEND_MAX = '1;

  state_t                  state;
  state_t                  state_nx;
  logic                    sig_prev;
  logic                    ack_sync;
  logic                    evt;
  logic                    start;
  logic                    take_direct;
  logic                    pend_inc;
  logic                    pend_dec;
  logic                    timeout_hit;
  logic                    req_nx;
  logic                    done_nx;
  logic                    to_set;
  logic                    ovf_set;
  logic [PEND_WIDTH-1:0]   pend_nx;
  logic [TO_W-1:0]         wait_cnt;

  sync_ff_chain #(
    .STAGES(SYNC_STAGES)
  ) u_ack_sync (
    .clk  (clk),
    .reset(reset),
    .d    (ack_in),
    .q    (ack_sync)
  );

  assign evt         = signal_in & ~sig_prev;
  assign start       = (state == ST_IDLE) && (evt || (pending != '0));
  // Only an event arriving with an empty queue is consumed directly; any other
  // event joins the queue, so IDLE+pending+event nets to no change.
  assign take_direct = start && (pending == '0);
  assign pend_dec    = start && (pending != '0);
  assign pend_inc    = evt && !take_direct;
  assign timeout_hit = (state != ST_IDLE) && (wait_cnt == TO_LAST);
  assign busy        = (state != ST_IDLE);

  always_comb begin
    pend_nx = pending;
    ovf_set = 1'b0;
    if (pend_inc && !pend_dec) begin
      if (pending == PEND_MAX) begin
        ovf_set = 1'b1;
      end else begin
        pend_nx = pending + 1'b1;
      end
    end else if (pend_dec && !pend_inc) begin
      pend_nx = pending - 1'b1;
    end
  end

  always_comb begin
    state_nx = state;
    req_nx   = req_out;
    done_nx  = 1'b0;
    to_set   = 1'b0;
    case (state)
      ST_IDLE: begin
        req_nx = 1'b0;
        if (start) begin
          state_nx = ST_REQ_HI;
          req_nx   = 1'b1;
        end
      end
      ST_REQ_HI: begin
        if (ack_sync) begin
          state_nx = ST_ACK_WAIT_LO;
          req_nx   = 1'b0;
        end else if (timeout_hit) begin
          state_nx = ST_IDLE;
          req_nx   = 1'b0;
          to_set   = 1'b1;
        end
      end
      ST_ACK_WAIT_LO: begin
        req_nx = 1'b0;
        if (!ack_sync) begin
          state_nx = ST_IDLE;
          done_nx  = 1'b1;
        end else if (timeout_hit) begin
          state_nx = ST_IDLE;
          to_set   = 1'b1;
        end
      end
      default: begin
        state_nx = ST_IDLE;
        req_nx   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      req_out     <= 1'b0;
      done        <= 1'b0;
      pending     <= '0;
      overflow    <= 1'b0;
      timeout_err <= 1'b0;
      wait_cnt    <= '0;
      sig_prev    <= 1'b0;
    end else begin
      state       <= state_nx;
      req_out     <= req_nx;
      done        <= done_nx;
      pending     <= pend_nx;
      overflow    <= overflow | ovf_set;
      timeout_err <= timeout_err | to_set;
      sig_prev    <= signal_in;
      // Leaving a wait state at TO_LAST keeps the counter from ever wrapping.
      if (state_nx != state) begin
        wait_cnt <= '0;
      end else if (state != ST_IDLE) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pulse_req_sender.sv
// Self-checking bench for pulse_req_sender: directed handshake scenarios plus
// randomized event bursts against a far-side responder with random latency.
module tb_pulse_req_sender;

  localparam int unsigned PW = 2;
  localparam int unsigned TO = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          signal_in = 1'b0;
  logic          ack_in = 1'b0;
  logic          req_out;
  logic          busy;
  logic          done;
  logic [PW-1:0] pending;
  logic          overflow;
  logic          timeout_err;

  int checks = 0;
  int errors = 0;
  int done_total = 0;
  int gap_viol = 0;

  bit          resp_en = 1'b0;
  int          resp_dly = 1;
  logic [15:0] hist = '0;
  logic        prev_req = 1'b0;
  logic        prev_busy = 1'b0;
  logic        prev_done = 1'b0;

  pulse_req_sender #(
    .SYNC_STAGES   (2),
    .PEND_WIDTH    (PW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .signal_in  (signal_in),
    .ack_in     (ack_in),
    .req_out    (req_out),
    .busy       (busy),
    .done       (done),
    .pending    (pending),
    .overflow   (overflow),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // Far-side receiver: ack follows req_out delayed by resp_dly-1 cycles.
  always @(posedge clk) begin
    #1;
    hist   = {hist[14:0], req_out};
    ack_in = resp_en ? hist[resp_dly-1] : 1'b0;
  end

  // Protocol observer: counts done pulses and protocol violations.
  always @(negedge clk) begin
    if (done === 1'b1) done_total++;
    if (req_out === 1'b1 && prev_req === 1'b0 && prev_busy === 1'b1) gap_viol++;
    if (done === 1'b1 && (prev_done === 1'b1 || busy === 1'b1)) gap_viol++;
    prev_req  = req_out;
    prev_busy = busy;
    prev_done = done;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset     = 1'b1;
    signal_in = 1'b0;
    resp_en   = 1'b0;
    repeat (10) tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (!(busy === 1'b0 && pending === '0) && n < 300) begin
      tick();
      n++;
    end
    checks++;
    if (n >= 300) begin
      errors++;
      $display("FAIL %s_drain: busy=%b pending=%0d after %0d cycles, required idle", name, busy, pending, n);
    end
    repeat (2) tick();
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    signal_in = 1'b0;
    resp_en   = 1'b0;
    repeat (10) tick();
    checks += 6;
    if (req_out !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", req_out); end
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    if (pending !== '0) begin errors++; $display("FAIL reset_pending: got %0d want 0", pending); end
    if (overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b want 0", overflow); end
    if (timeout_err !== 1'b0) begin errors++; $display("FAIL reset_to: got %b want 0", timeout_err); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_single();
    int base;
    apply_reset();
    resp_en  = 1'b1;
    resp_dly = 4;
    base     = done_total;
    signal_in = 1'b1;
    checks++;
    if (req_out !== 1'b0) begin errors++; $display("FAIL single_req_early: got %b want 0", req_out); end
    tick();
    checks += 3;
    if (req_out !== 1'b1) begin errors++; $display("FAIL single_req_latency: got %b want 1", req_out); end
    if (busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %b want 1", busy); end
    if (pending !== '0) begin errors++; $display("FAIL single_pending_direct: got %0d want 0", pending); end
    repeat (2) tick();
    signal_in = 1'b0;
    wait_idle("single");
    checks += 4;
    if (done_total - base != 1) begin errors++; $display("FAIL single_done_count: got %0d want 1", done_total - base); end
    if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_after: got %b want 0", busy); end
    if (req_out !== 1'b0) begin errors++; $display("FAIL single_req_after: got %b want 0", req_out); end
    if (timeout_err !== 1'b0) begin errors++; $display("FAIL single_to: got %b want 0", timeout_err); end
  endtask

  task automatic test_queue();
    int base;
    logic [PW-1:0] maxp;
    apply_reset();
    resp_en  = 1'b1;
    resp_dly = 8;
    base     = done_total;
    maxp     = '0;
    for (int j = 0; j < 16; j++) begin
      signal_in = ((j % 4) < 2);
      tick();
      if (pending > maxp) maxp = pending;
    end
    signal_in = 1'b0;
    wait_idle("queue");
    checks += 4;
    if (maxp !== 2'd3) begin errors++; $display("FAIL queue_peak: got %0d want 3", maxp); end
    if (done_total - base != 4) begin errors++; $display("FAIL queue_done_count: got %0d want 4", done_total - base); end
    if (pending !== '0) begin errors++; $display("FAIL queue_pending_end: got %0d want 0", pending); end
    if (overflow !== 1'b0) begin errors++; $display("FAIL queue_ovf: got %b want 0", overflow); end
  endtask

  task automatic test_overflow();
    int base;
    apply_reset();
    base = done_total;
    for (int j = 0; j < 10; j++) begin
      signal_in = (j % 2 == 0);
      tick();
      if (j == 6) begin
        checks += 2;
        if (pending !== 2'd3) begin errors++; $display("FAIL ovf_full: got %0d want 3", pending); end
        if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_early: got %b want 0", overflow); end
      end
    end
    signal_in = 1'b0;
    checks += 3;
    if (pending !== 2'd3) begin errors++; $display("FAIL ovf_saturate: got %0d want 3", pending); end
    if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b want 1", overflow); end
    if (req_out !== 1'b1) begin errors++; $display("FAIL ovf_stalled_req: got %b want 1", req_out); end
    resp_en  = 1'b1;
    resp_dly = 2;
    wait_idle("ovf");
    checks += 3;
    if (done_total - base != 4) begin errors++; $display("FAIL ovf_done_count: got %0d want 4", done_total - base); end
    if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b want 1", overflow); end
    if (timeout_err !== 1'b0) begin errors++; $display("FAIL ovf_to: got %b want 0", timeout_err); end
  endtask

  task automatic test_timeout();
    int base;
    resp_en = 1'b0;
    repeat (6) tick();
    base = done_total;
    checks++;
    if (timeout_err !== 1'b0) begin errors++; $display("FAIL to_pre: got %b want 0", timeout_err); end
    signal_in = 1'b1;
    tick();
    signal_in = 1'b0;
    checks++;
    if (req_out !== 1'b1) begin errors++; $display("FAIL to_req_start: got %b want 1", req_out); end
    repeat (TO - 1) tick();
    checks += 2;
    if (timeout_err !== 1'b0) begin errors++; $display("FAIL to_early: got %b want 0", timeout_err); end
    if (req_out !== 1'b1) begin errors++; $display("FAIL to_req_held: got %b want 1", req_out); end
    tick();
    checks += 3;
    if (timeout_err !== 1'b1) begin errors++; $display("FAIL to_flag: got %b want 1", timeout_err); end
    if (req_out !== 1'b0) begin errors++; $display("FAIL to_req_drop: got %b want 0", req_out); end
    if (busy !== 1'b0) begin errors++; $display("FAIL to_busy: got %b want 0", busy); end
    repeat (5) tick();
    checks += 3;
    if (timeout_err !== 1'b1) begin errors++; $display("FAIL to_sticky: got %b want 1", timeout_err); end
    if (done_total - base != 0) begin errors++; $display("FAIL to_no_done: got %0d want 0", done_total - base); end
    if (overflow !== 1'b1) begin errors++; $display("FAIL to_ovf_kept: got %b want 1", overflow); end
  endtask

  task automatic test_reset_mid();
    for (int j = 0; j < 6; j++) begin
      signal_in = (j % 2 == 0);
      tick();
    end
    signal_in = 1'b0;
    checks += 2;
    if (pending !== 2'd2) begin errors++; $display("FAIL rmid_pre_pending: got %0d want 2", pending); end
    if (busy !== 1'b1) begin errors++; $display("FAIL rmid_pre_busy: got %b want 1", busy); end
    reset = 1'b1;
    tick();
    checks += 5;
    if (req_out !== 1'b0) begin errors++; $display("FAIL rmid_req: got %b want 0", req_out); end
    if (pending !== '0) begin errors++; $display("FAIL rmid_pending: got %0d want 0", pending); end
    if (busy !== 1'b0) begin errors++; $display("FAIL rmid_busy: got %b want 0", busy); end
    if (overflow !== 1'b0) begin errors++; $display("FAIL rmid_ovf: got %b want 0", overflow); end
    if (timeout_err !== 1'b0) begin errors++; $display("FAIL rmid_to: got %b want 0", timeout_err); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_edge_at_done();
    int  base;
    int  n;
    apply_reset();
    resp_en  = 1'b1;
    resp_dly = 2;
    base     = done_total;
    signal_in = 1'b1; tick();
    signal_in = 1'b0; tick();
    signal_in = 1'b1; tick();
    signal_in = 1'b0; tick();
    checks++;
    if (pending !== 2'd1) begin errors++; $display("FAIL edone_pending_pre: got %0d want 1", pending); end
    n = 0;
    while (done !== 1'b1 && n < 60) begin
      tick();
      n++;
    end
    checks += 4;
    if (n >= 60) begin errors++; $display("FAIL edone_wait: no done within %0d cycles, required a pulse", n); end
    if (busy !== 1'b0) begin errors++; $display("FAIL edone_idle_gap: busy=%b want 0", busy); end
    if (req_out !== 1'b0) begin errors++; $display("FAIL edone_req_gap: got %b want 0", req_out); end
    if (pending !== 2'd1) begin errors++; $display("FAIL edone_pending_at_done: got %0d want 1", pending); end
    signal_in = 1'b1;
    tick();
    signal_in = 1'b0;
    checks += 2;
    if (pending !== 2'd1) begin errors++; $display("FAIL edone_pending_same: got %0d want 1", pending); end
    if (req_out !== 1'b1) begin errors++; $display("FAIL edone_next_req: got %b want 1", req_out); end
    wait_idle("edone");
    checks++;
    if (done_total - base != 3) begin errors++; $display("FAIL edone_done_count: got %0d want 3", done_total - base); end
  endtask

  task automatic test_random();
    int   base;
    int   edges;
    logic prev;
    logic lvl;
    apply_reset();
    for (int b = 0; b < 20; b++) begin
      resp_en  = 1'b1;
      resp_dly = $urandom_range(1, 6);
      base     = done_total;
      edges    = 0;
      prev     = 1'b0;
      for (int i = 0; i < 12; i++) begin
        lvl = 1'($urandom_range(0, 1));
        if (lvl && !prev && edges == 3) lvl = 1'b0;
        if (lvl && !prev) edges++;
        signal_in = lvl;
        prev      = lvl;
        tick();
      end
      signal_in = 1'b0;
      repeat (2) tick();
      wait_idle("rand");
      checks += 4;
      if (done_total - base != edges) begin errors++; $display("FAIL rand_done_count: burst %0d got %0d want %0d", b, done_total - base, edges); end
      if (pending !== '0) begin errors++; $display("FAIL rand_pending: burst %0d got %0d want 0", b, pending); end
      if (overflow !== 1'b0) begin errors++; $display("FAIL rand_ovf: burst %0d got %b want 0", b, overflow); end
      if (timeout_err !== 1'b0) begin errors++; $display("FAIL rand_to: burst %0d got %b want 0", b, timeout_err); end
      repeat (8) tick();
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_queue();
    test_overflow();
    test_timeout();
    test_reset_mid();
    test_edge_at_done();
    test_random();
    checks++;
    if (gap_viol != 0) begin errors++; $display("FAIL protocol_gap: got %0d violations want 0", gap_viol); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pulse_req_sender.md
PULSE_REQ_SENDER -- requirements
Module: pulse_req_sender

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, number of flops synchronizing ack_in (minimum 2).
REQ-002 SHALL have parameter PEND_WIDTH, default 4, width of the pending-event counter (capacity 2^PEND_WIDTH-1).
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 1024, maximum cycles spent in any wait state before abort.
REQ-004 SHALL have port clk, input, 1, the single clock; all logic SHALL be on its rising edge.
REQ-005 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-006 SHALL have port signal_in, input, 1, local event level; each rising edge is one event.
REQ-007 SHALL have port ack_in, input, 1, asynchronous acknowledge level returned by the far-side receiver.
REQ-008 SHALL have port req_out, input-free registered output, 1, request level crossing to the far domain.
REQ-009 SHALL have port busy, output, 1, high whenever the state is not IDLE.
REQ-010 SHALL have port done, output, 1, one-cycle pulse on each completed four-phase handshake.
REQ-011 SHALL have port pending, output, PEND_WIDTH, events accepted but not yet started.
REQ-012 SHALL have port overflow, output, 1, sticky flag: an event was lost.
REQ-013 SHALL have port timeout_err, output, 1, sticky flag: a handshake was aborted.

Function
REQ-014 SHALL detect an event when signal_in is 1 and its registered previous value is 0.
REQ-015 SHALL pass ack_in through SYNC_STAGES flops; ack_sync denotes the last stage; only ack_sync SHALL be used.
REQ-016 SHALL implement states IDLE, REQ_HI, ACK_WAIT_LO.
REQ-017 IDLE: if an event is detected or pending>0, SHALL go to REQ_HI, with req_out=1 from the next cycle; an event taken directly SHALL NOT increment pending, otherwise pending SHALL decrement by 1.
REQ-018 REQ_HI: req_out=1; on ack_sync=1, SHALL go to ACK_WAIT_LO with req_out=0 from the next cycle.
REQ-019 ACK_WAIT_LO: req_out=0; on ack_sync=0, SHALL pulse done for one cycle and go to IDLE.
REQ-020 An event detected while not in IDLE, or while IDLE but pending>0, SHALL increment pending.
REQ-021 Event and decrement in the same cycle SHALL leave pending unchanged.
REQ-022 An event arriving when pending=2^PEND_WIDTH-1 with no decrement SHALL leave pending saturated and set overflow.
REQ-023 A cycle counter SHALL clear on every state entry and count in REQ_HI and ACK_WAIT_LO.
REQ-024 Reaching TIMEOUT_CYCLES SHALL set timeout_err, force req_out=0, and go to IDLE without pulsing done; pending SHALL be kept.
REQ-025 Handshake latency SHALL be: event at edge n -> req_out=1 at edge n+1; back-to-back requests SHALL be separated by at least one IDLE cycle with req_out=0.
REQ-026 Counter widths SHALL be derived with $clog2; no arithmetic wrap SHALL occur.

Reset
REQ-027 Reset SHALL set state=IDLE and clear req_out, busy, done, pending, overflow, timeout_err, the timeout counter, the sync flops and the edge register.
REQ-028 Reset mid-handshake SHALL drop req_out the next cycle and discard all pending events.
REQ-029 overflow and timeout_err SHALL clear only on reset.

Structure
REQ-030 State encodings and the default parameter values SHALL live in shared package pulse_hs_pkg.
REQ-031 The ack synchronizer SHALL be sub-module sync_ff_chain (parameter STAGES); the FSM and counters SHALL stay in pulse_req_sender.

Verification
REQ-032 Single edge; ack_in rises 3 cycles after req_out and falls 3 cycles after req_out drops -> req_out high at n+1, done=1 exactly once, pending=0, busy low afterwards.
REQ-033 Three edges 4 cycles apart during one handshake -> pending reaches 3, three more handshakes, three more done pulses, pending returns to 0.
REQ-034 PEND_WIDTH=2, 5 edges during a stalled handshake -> pending=3, overflow=1, four done pulses in total.
REQ-035 ack_in held 0, TIMEOUT_CYCLES=16 -> timeout_err=1 at 16 cycles in REQ_HI, req_out=0, no done pulse.
REQ-036 Reset asserted while in REQ_HI with pending=2 -> next cycle req_out=0, pending=0, busy=0, and flags clear.
REQ-037 Edge in the same cycle as the done pulse, with pending=1 -> pending stays 1, and the next request starts after one IDLE cycle.
